// File: rtl/jellyvl_etherneco_packet_rx.sv
// Etherneco packet receiver: splits a byte stream into header fields and payload.
// Optional node filter: define JELLYVL_ETHERNECO_PACKET_RX_NODE_FILTER_EN.
module jellyvl_etherneco_packet_rx #(
  parameter logic [7:0] NODE_ID = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_rx_first,
  input  logic        s_rx_last,
  input  logic [7:0]  s_rx_data,
  input  logic        s_rx_valid,
  output logic        rx_start,
  output logic [7:0]  rx_node,
  output logic [7:0]  rx_type,
  output logic [15:0] rx_length,
  output logic        m_first,
  output logic        m_last,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        rx_end,
  output logic        rx_error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  state_t      r_state, w_state;
  logic [1:0]  r_idx, w_idx;
  logic [15:0] r_cnt, w_cnt;
  logic        r_pend, w_pend;
  logic        r_filt, w_filt;
  logic [7:0]  r_node, w_node;
  logic [7:0]  r_type, w_type;
  logic [15:0] r_len, w_len;
  logic [7:0]  r_mdata, w_mdata;
  logic        r_start, w_start;
  logic        r_end, w_end;
  logic        r_err, w_err;
  logic        r_mvalid, w_mvalid;
  logic        r_mfirst, w_mfirst;
  logic        r_mlast, w_mlast;
  logic        w_accept;

`ifdef JELLYVL_ETHERNECO_PACKET_RX_NODE_FILTER_EN
  assign w_accept = (r_node == NODE_ID) || (r_node == 8'hFF);
`else
  logic [7:0] w_unused_node_id;
  assign w_unused_node_id = NODE_ID;
  assign w_accept = 1'b1;
`endif

  // Next-state, counter, field and pulse decode for one accepted byte.
  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_cnt    = r_cnt;
    w_pend   = r_pend;
    w_filt   = r_filt;
    w_node   = r_node;
    w_type   = r_type;
    w_len    = r_len;
    w_mdata  = r_mdata;
    w_start  = 1'b0;
    w_end    = 1'b0;
    w_err    = 1'b0;
    w_mvalid = 1'b0;
    w_mfirst = 1'b0;
    w_mlast  = 1'b0;
    if (s_rx_valid) begin
      if (s_rx_first) begin
        // A new frame start always wins; mid-frame it aborts the old one.
        w_err   = (r_state != ST_IDLE);
        w_node  = s_rx_data;
        w_idx   = 2'd1;
        w_filt  = 1'b0;
        w_state = ST_HEADER;
      end else begin
        case (r_state)
          ST_HEADER: begin
            if (s_rx_last) begin
              w_err   = 1'b1;
              w_state = ST_IDLE;
            end else begin
              case (r_idx)
                2'd1: begin
                  w_type = s_rx_data;
                  w_idx  = 2'd2;
                end
                2'd2: begin
                  w_len[7:0] = s_rx_data;
                  w_idx      = 2'd3;
                end
                2'd3: begin
                  w_len[15:8] = s_rx_data;
                  w_cnt       = {s_rx_data, r_len[7:0]};
                  w_pend      = 1'b1;
                  w_idx       = 2'd0;
                  if (w_accept) begin
                    w_start = 1'b1;
                    w_state = ST_PAYLOAD;
                  end else begin
                    w_filt  = 1'b1;
                    w_state = ST_DROP;
                  end
                end
                default: w_idx = 2'd1;
              endcase
            end
          end
          ST_PAYLOAD: begin
            w_mvalid = 1'b1;
            w_mdata  = s_rx_data;
            w_mfirst = r_pend;
            w_pend   = 1'b0;
            w_mlast  = (r_cnt == 16'd0) || s_rx_last;
            if (s_rx_last) begin
              w_end   = (r_cnt == 16'd0);
              w_err   = (r_cnt != 16'd0);
              w_state = ST_IDLE;
            end else if (r_cnt == 16'd0) begin
              w_filt  = 1'b0;
              w_state = ST_DROP;
            end else begin
              w_cnt = r_cnt - 16'd1;
            end
          end
          ST_DROP: begin
            if (s_rx_last) begin
              w_err   = !r_filt;
              w_filt  = 1'b0;
              w_state = ST_IDLE;
            end
          end
          default: w_state = ST_IDLE;
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= 2'd0;
      r_cnt    <= 16'd0;
      r_pend   <= 1'b0;
      r_filt   <= 1'b0;
      r_node   <= 8'd0;
      r_type   <= 8'd0;
      r_len    <= 16'd0;
      r_mdata  <= 8'd0;
      r_start  <= 1'b0;
      r_end    <= 1'b0;
      r_err    <= 1'b0;
      r_mvalid <= 1'b0;
      r_mfirst <= 1'b0;
      r_mlast  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_idx    <= w_idx;
      r_cnt    <= w_cnt;
      r_pend   <= w_pend;
      r_filt   <= w_filt;
      r_node   <= w_node;
      r_type   <= w_type;
      r_len    <= w_len;
      r_mdata  <= w_mdata;
      r_start  <= w_start;
      r_end    <= w_end;
      r_err    <= w_err;
      r_mvalid <= w_mvalid;
      r_mfirst <= w_mfirst;
      r_mlast  <= w_mlast;
    end
  end

  assign rx_start  = r_start;
  assign rx_node   = r_node;
  assign rx_type   = r_type;
  assign rx_length = r_len;
  assign m_first   = r_mfirst;
  assign m_last    = r_mlast;
  assign m_data    = r_mdata;
  assign m_valid   = r_mvalid;
  assign rx_end    = r_end;
  assign rx_error  = r_err;

endmodule
